mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the RV32I pipeline, directly downstream of the execute stage.
- Consumes the EXE/MEM register outputs (pc_mem, alu_mem, rs2_mem, instr_mem, rd_addr_mem).
- Performs loads and stores against a data memory with a req/ack handshake and variable latency.
- Aligns, extends or replicates data, stalls the pipeline while memory is busy, and drives the MEM/WB registers plus the MEM forwarding value.

Parameters:
- XLEN, 32, datapath width.
- DMEM_WIDTH, 10, word-address width of data memory.
- NOP_INSTR, 32'h00000013, instruction word inserted as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pc_mem  in  XLEN  PC from EXE/MEM.
- alu_mem  in  XLEN  ALU result / effective address.
- rs2_mem  in  XLEN  store data (already forwarded).
- instr_mem  in  XLEN  instruction word.
- rd_addr_mem  in  5  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_be  out  4  byte enables.
- dmem_addr  out  DMEM_WIDTH  word address = alu_mem[DMEM_WIDTH+1:2].
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rdata  in  XLEN  load data, valid with ack.
- dmem_ack  in  1  access complete.
- stall_mem  out  1  to hazard unit: freeze PC, IF/ID, ID/EXE, EXE/MEM.
- misalign_mem  out  1  misaligned access flag (combinational).
- forward_mem  out  XLEN  = alu_mem, to execute forwarding mux.
- pc_wb  out  XLEN  MEM/WB PC.
- alu_wb  out  XLEN  MEM/WB ALU result.
- load_wb  out  XLEN  MEM/WB aligned, extended load data.
- instr_wb  out  XLEN  MEM/WB instruction.
- rd_addr_wb  out  5  MEM/WB destination register.

Behaviour:
- Reset value of every output.
  - Async reset while rst=0 clears FSM to IDLE and all MEM/WB registers: instr_wb=0, pc_wb=0, alu_wb=0, load_wb=0, rd_addr_wb=0.
  - dmem_req=0, stall_mem=0 during reset.
  - Reset mid-access abandons the access; a late ack after reset is ignored in IDLE.
- Instruction decode.
  - Load: opcode 0000011. Store: opcode 0100011. Width from funct3 = instr_mem[14:12].
  - off = alu_mem[1:0].
- Misalignment.
  - Misaligned when: halfword with off[0]=1, or word with off!=0.
  - Misaligned access raises misalign_mem, issues no request, writes a bubble to MEM/WB, and does not stall.
- Store byte enables and data.
  - SB: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'hF, wdata = rs2.
  - Loads: be=4'hF, we=0.
- Load data (from dmem_rdata).
  - LB: lane selected by off, sign-extended. LBU: same lane, zero-extended.
  - LH: half selected by off[1], sign-extended. LHU: same half, zero-extended.
  - LW: full word.
  - Unused funct3 values are treated as LW.
- FSM states: IDLE, WAIT.
  - IDLE, aligned load/store present: dmem_req=1 combinationally.
    - ack same cycle: zero-wait. MEM/WB captures the instruction at the next edge; stall_mem=0; stay IDLE.
    - no ack: stall_mem=1, next state WAIT, MEM/WB loads bubble.
  - WAIT: dmem_req=1 held, address/we/be/wdata stable (inputs frozen by stall).
    - no ack: stall_mem=1, MEM/WB loads bubble.
    - ack: stall_mem=0, MEM/WB captures the instruction and load data, next state IDLE.
  - Non-memory instruction in IDLE: no request; MEM/WB captures the instruction; load_wb=0.
- Stall logic: stall_mem = access & ~dmem_ack, in either state.
- Bubble contents: instr_wb=NOP_INSTR, rd_addr_wb=0, pc_wb/alu_wb/load_wb = 0.
- Back-to-back accesses: the next access is accepted in IDLE on the cycle after the ack edge.
- forward_mem is combinational from alu_mem in all states. The load-use hazard is owned by the hazard unit, not this block.

Decomposition:
- Shared package/constants header gains:
  - OPC_LOAD, OPC_STORE.
  - F3_B/H/W/BU/HU.
  - MEM_STATE typedef {IDLE, WAIT}.
  - NOP_INSTR.
- Natural sub-module: mem_align. Pure combinational; inputs funct3, off, rs2, rdata; outputs be, wdata, load data, misalign.
- mem_stage holds the FSM and the MEM/WB registers.

Test Plan:
- SW alu_mem=0x104, rs2=0xDEADBEEF, ack same cycle -> dmem_addr=0x41, be=F, wdata=0xDEADBEEF, we=1, stall_mem never high, instr_wb=store next cycle.
- SB off=3 rs2=0x000000A5, ack after 3 cycles -> be=4'b1000, wdata=0xA5A5A5A5, stall_mem high exactly 3 cycles, 3 NOP bubbles in instr_wb, req held stable.
- LB off=1 rdata=0x0000_80_00 -> load_wb=0xFFFFFF80. LBU same -> 0x00000080. LH off=2 rdata=0x8001_0000 -> 0xFFFF8001.
- LW alu_mem=0x102 -> misalign_mem=1, dmem_req=0, stall_mem=0, instr_wb=NOP_INSTR, rd_addr_wb=0.
- Load in WAIT, assert rst=0 for 1 cycle, then ack -> all outputs zero during reset, FSM IDLE, late ack produces no MEM/WB write.
- ADD alu_mem=0x1234, rd=5 -> no req, forward_mem=0x1234 same cycle, alu_wb=0x1234, rd_addr_wb=5 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the RV32I memory stage: opcodes, load/store widths,
// the access FSM state type and the pipeline bubble instruction.
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// request/ack handshake with variable latency.
interface mem_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DMEM_WIDTH = 10
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [3:0]            dmem_be;
  logic [DMEM_WIDTH-1:0] dmem_addr;
  logic [XLEN-1:0]       dmem_wdata;
  logic [XLEN-1:0]       dmem_rdata;
  logic                  dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store byte enables and lane replication, load lane
// extraction with sign/zero extension, and misalignment detection.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rdata[{i_off, 3'b000} +: 8];
    w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be        = 4'hF;
    o_wdata     = i_rs2;
    o_load_data = i_rdata;
    o_misalign  = 1'b0;
    // Any funct3 outside the byte/half encodings behaves as a full word
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be        = 4'b0001 << i_off;
        o_wdata     = {4{i_rs2[7:0]}};
        o_load_data = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      F3_H, F3_HU: begin
        o_be        = 4'b0011 << i_off;
        o_wdata     = {2{i_rs2[15:0]}};
        o_load_data = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        o_misalign  = i_off[0];
      end
      default: begin
        o_misalign = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on the data-memory bus, stalls the pipeline
// while an access is outstanding and drives the MEM/WB registers.
module mem_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DMEM_WIDTH = 10,
  parameter logic [XLEN-1:0] NOP_INSTR  = mem_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  input  logic [4:0]      rd_addr_mem,
  mem_stage_if.master     dmem,
  output logic            stall_mem,
  output logic            misalign_mem,
  output logic [XLEN-1:0] forward_mem,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] load_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic [4:0]      rd_addr_wb
);
  import mem_stage_pkg::*;

  mem_state_t      r_state;
  mem_state_t      w_state_d;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_access;
  logic            w_req;
  logic            w_bubble;
  logic            w_misalign;
  logic [3:0]      w_be_st;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  logic [XLEN-1:0] r_pc_wb;
  logic [XLEN-1:0] r_alu_wb;
  logic [XLEN-1:0] r_load_wb;
  logic [XLEN-1:0] r_instr_wb;
  logic [4:0]      r_rd_addr_wb;

  assign w_is_load  = (instr_mem[6:0] == OPC_LOAD);
  assign w_is_store = (instr_mem[6:0] == OPC_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

  mem_stage_align u_align (
    .i_funct3    (instr_mem[14:12]),
    .i_off       (alu_mem[1:0]),
    .i_rs2       (rs2_mem),
    .i_rdata     (dmem.dmem_rdata),
    .o_be        (w_be_st),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );

  assign misalign_mem = w_is_mem & w_misalign;
  assign w_access     = w_is_mem & ~w_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: if (w_access && !dmem.dmem_ack) w_state_d = WAIT;
      WAIT: if (dmem.dmem_ack) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      IDLE:    w_req = w_access;
      WAIT:    w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  // Request is masked while reset is held so memory never sees a stray access
  assign dmem.dmem_req   = w_req & rst;
  assign dmem.dmem_we    = w_is_store;
  assign dmem.dmem_be    = w_is_store ? w_be_st : 4'hF;
  assign dmem.dmem_addr  = alu_mem[DMEM_WIDTH+1:2];
  assign dmem.dmem_wdata = w_wdata;

  assign stall_mem   = dmem.dmem_req & ~dmem.dmem_ack;
  assign forward_mem = alu_mem;
  assign w_bubble    = stall_mem | misalign_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc_wb      <= '0;
      r_alu_wb     <= '0;
      r_load_wb    <= '0;
      r_instr_wb   <= '0;
      r_rd_addr_wb <= '0;
    end else if (w_bubble) begin
      r_pc_wb      <= '0;
      r_alu_wb     <= '0;
      r_load_wb    <= '0;
      r_instr_wb   <= NOP_INSTR;
      r_rd_addr_wb <= '0;
    end else begin
      r_pc_wb      <= pc_mem;
      r_alu_wb     <= alu_mem;
      r_load_wb    <= w_is_load ? w_load_data : '0;
      r_instr_wb   <= instr_mem;
      r_rd_addr_wb <= rd_addr_mem;
    end
  end

  assign pc_wb      = r_pc_wb;
  assign alu_wb     = r_alu_wb;
  assign load_wb    = r_load_wb;
  assign instr_wb   = r_instr_wb;
  assign rd_addr_wb = r_rd_addr_wb;

endmodule
